// File: rtl/evt_flag_sched.sv
// evt_flag_sched: sticky event flags with round-robin interrupt presentation to the PS
module evt_flag_sched #(
   parameter int N_EVT = 8,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_EVT-1:0] i_evt_pulse,
   input  logic [N_EVT-1:0] i_evt_mask,
   input  logic [N_EVT-1:0] i_clear_reg,
   input  logic             i_ack_reg,
   output logic [N_EVT-1:0] o_flags,
   output logic [N_EVT-1:0] o_ovf,
   output logic             o_irq,
   output logic [ID_W-1:0]  o_irq_id,
   output logic             o_pending
);
   typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;
   state_t state, state_nx;
   logic [N_EVT-1:0] clr_d, clr_p, clr_all, flags_nx, ovf_nx, req;
   logic ack_d, ack_p, ack_hit, irq_nx;
   logic [ID_W-1:0] rr_ptr, rr_nx, pick, idx, id_nx;
   assign clr_p    = i_clear_reg & ~clr_d;
   assign ack_p    = i_ack_reg & ~ack_d;
   assign ack_hit  = (state == ASSERT) && ack_p;
   // an acknowledge clears the presented flag exactly like a PS clear edge, so set still wins
   assign clr_all  = clr_p | (ack_hit ? {{(N_EVT-1){1'b0}}, 1'b1} << o_irq_id : '0);
   assign flags_nx = i_evt_pulse | (o_flags & ~clr_all);
   assign ovf_nx   = (o_ovf | (i_evt_pulse & o_flags)) & ~clr_all;
   assign req      = o_flags & i_evt_mask;
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int i = N_EVT - 1; i >= 0; i--) begin
         idx = ID_W'((int'(rr_ptr) + i) % N_EVT);
         if (req[idx]) pick = idx;
      end
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = |req ? ASSERT : IDLE;
         ASSERT:  state_nx = (ack_p || clr_p[o_irq_id]) ? GAP : ASSERT;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      irq_nx = o_irq;
      id_nx  = o_irq_id;
      rr_nx  = rr_ptr;
      case (state)
         IDLE: begin
            irq_nx = |req;
            id_nx  = |req ? pick : o_irq_id;
         end
         ASSERT: begin
            irq_nx = !(ack_p || clr_p[o_irq_id]);
            rr_nx  = !ack_p ? rr_ptr : (o_irq_id == ID_W'(N_EVT - 1)) ? '0 : o_irq_id + ID_W'(1);
         end
         default: irq_nx = 1'b0;
      endcase
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         clr_d     <= '0;
         ack_d     <= 1'b0;
         o_flags   <= '0;
         o_ovf     <= '0;
         o_pending <= 1'b0;
         o_irq     <= 1'b0;
         o_irq_id  <= '0;
         rr_ptr    <= '0;
      end else begin
         clr_d     <= i_clear_reg;
         ack_d     <= i_ack_reg;
         o_flags   <= flags_nx;
         o_ovf     <= ovf_nx;
         o_pending <= |(flags_nx & i_evt_mask);
         o_irq     <= irq_nx;
         o_irq_id  <= id_nx;
         rr_ptr    <= rr_nx;
      end
endmodule

// File: tb/tb_evt_flag_sched.sv
// tb_evt_flag_sched: scoreboard-driven checks of flag setting, clearing and irq scheduling
module tb_evt_flag_sched;
   localparam int N = 8;
   localparam int W = 3;
   logic clk = 1'b0, rstn;
   logic [N-1:0] i_evt_pulse, i_evt_mask, i_clear_reg;
   logic i_ack_reg;
   logic [N-1:0] o_flags, o_ovf;
   logic o_irq, o_pending;
   logic [W-1:0] o_irq_id;
   int vectors = 0, miscompares = 0;
   int exp_q[$];

   evt_flag_sched #(.N_EVT(N), .ID_W(W)) dut (
      .clk(clk), .rstn(rstn), .i_evt_pulse(i_evt_pulse), .i_evt_mask(i_evt_mask),
      .i_clear_reg(i_clear_reg), .i_ack_reg(i_ack_reg), .o_flags(o_flags), .o_ovf(o_ovf),
      .o_irq(o_irq), .o_irq_id(o_irq_id), .o_pending(o_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rstn = 1'b0;
      i_evt_pulse = '0;
      i_evt_mask = '0;
      i_clear_reg = '0;
      i_ack_reg = 1'b0;
      exp_q.delete();
      repeat (2) tick;
      rstn = 1'b1;
      tick;
   endtask

   task automatic do_ack;
      i_ack_reg = 1'b1;
      tick;
      i_ack_reg = 1'b0;
   endtask

   task automatic wait_irq(input int budget, output bit ok);
      int n = 0;
      while (!o_irq && n < budget) begin
         tick;
         n++;
      end
      ok = o_irq;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      i_evt_pulse = '0;
      i_evt_mask = 8'hFF;
      i_clear_reg = '0;
      i_ack_reg = 1'b0;
      tick;
      vectors++;
      if ({o_flags, o_ovf, o_irq, o_irq_id, o_pending} !== '0)
         $display("FAIL reset_state: got %h expected 0", {o_flags, o_ovf, o_irq, o_irq_id, o_pending});
      rstn = 1'b1;
      repeat (2) tick;
      vectors++;
      if ({o_irq, o_flags} !== 9'h0)
         $display("FAIL reset_release: got %h expected 0", {o_irq, o_flags});
   endtask

   task automatic test_single;
      int e;
      i_evt_mask = 8'hFF;
      i_evt_pulse = 8'h04;
      tick;
      i_evt_pulse = '0;
      vectors++;
      if ({o_flags, o_irq, o_pending} !== {8'h04, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL single_set: got %h expected %h", {o_flags, o_irq, o_pending}, {8'h04, 1'b0, 1'b1});
      end
      exp_q.push_back(2);
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (o_irq !== 1'b1 || o_irq_id !== W'(e)) begin
         miscompares++;
         $display("FAIL single_irq: got irq=%b id=%0d expected irq=1 id=%0d", o_irq, o_irq_id, e);
      end
      do_ack;
      vectors++;
      if ({o_irq, o_flags, o_pending} !== 10'h0) begin
         miscompares++;
         $display("FAIL single_ack: got %h expected 0", {o_irq, o_flags, o_pending});
      end
      for (int k = 0; k < 3; k++) begin
         tick;
         vectors++;
         if (o_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL single_quiet: got irq=%b expected 0", o_irq);
         end
      end
   endtask

   task automatic test_round_robin;
      int e;
      bit ok;
      apply_reset;
      i_evt_mask = 8'hFF;
      i_evt_pulse = 8'h62;
      exp_q.push_back(1);
      exp_q.push_back(5);
      exp_q.push_back(6);
      tick;
      i_evt_pulse = '0;
      for (int k = 0; k < 3; k++) begin
         wait_irq(6, ok);
         e = exp_q.pop_front();
         vectors++;
         if (!ok || o_irq_id !== W'(e)) begin
            miscompares++;
            $display("FAIL rr_order: got irq=%b id=%0d expected irq=1 id=%0d", ok, o_irq_id, e);
         end
         do_ack;
      end
      i_evt_pulse = 8'h42;
      exp_q.push_back(1);
      exp_q.push_back(6);
      tick;
      i_evt_pulse = '0;
      for (int k = 0; k < 2; k++) begin
         wait_irq(6, ok);
         e = exp_q.pop_front();
         vectors++;
         if (!ok || o_irq_id !== W'(e)) begin
            miscompares++;
            $display("FAIL rr_wrap: got irq=%b id=%0d expected irq=1 id=%0d", ok, o_irq_id, e);
         end
         do_ack;
      end
      vectors++;
      if ({o_irq, o_flags} !== 9'h0) begin
         miscompares++;
         $display("FAIL rr_drain: got %h expected 0", {o_irq, o_flags});
      end
   endtask

   task automatic test_overrun;
      apply_reset;
      i_evt_pulse = 8'h08;
      tick;
      tick;
      i_evt_pulse = '0;
      vectors++;
      if ({o_flags, o_ovf} !== {8'h08, 8'h08}) begin
         miscompares++;
         $display("FAIL ovf_set: got %h expected %h", {o_flags, o_ovf}, {8'h08, 8'h08});
      end
      i_evt_pulse = 8'h08;
      i_clear_reg = 8'h08;
      tick;
      i_evt_pulse = '0;
      vectors++;
      if ({o_flags, o_ovf} !== {8'h08, 8'h00}) begin
         miscompares++;
         $display("FAIL set_wins: got %h expected %h", {o_flags, o_ovf}, {8'h08, 8'h00});
      end
      tick;
      vectors++;
      if (o_flags !== 8'h08) begin
         miscompares++;
         $display("FAIL clr_held: got %h expected 08", o_flags);
      end
      i_clear_reg = '0;
      tick;
      i_clear_reg = 8'h08;
      tick;
      i_clear_reg = '0;
      vectors++;
      if ({o_flags, o_ovf, o_irq} !== 17'h0) begin
         miscompares++;
         $display("FAIL clr_edge: got %h expected 0", {o_flags, o_ovf, o_irq});
      end
   endtask

   task automatic test_withdraw;
      int e;
      bit ok;
      apply_reset;
      i_evt_mask = 8'hFF;
      i_evt_pulse = 8'h10;
      exp_q.push_back(4);
      tick;
      i_evt_pulse = '0;
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (o_irq !== 1'b1 || o_irq_id !== W'(e)) begin
         miscompares++;
         $display("FAIL wd_present: got irq=%b id=%0d expected irq=1 id=%0d", o_irq, o_irq_id, e);
      end
      i_clear_reg = 8'h10;
      tick;
      i_clear_reg = '0;
      vectors++;
      if ({o_irq, o_flags} !== 9'h0) begin
         miscompares++;
         $display("FAIL wd_drop: got %h expected 0", {o_irq, o_flags});
      end
      i_evt_pulse = 8'h24;
      exp_q.push_back(2);
      exp_q.push_back(5);
      tick;
      i_evt_pulse = '0;
      wait_irq(6, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || o_irq_id !== W'(e)) begin
         miscompares++;
         $display("FAIL wd_rr: got irq=%b id=%0d expected irq=1 id=%0d", ok, o_irq_id, e);
      end
      i_ack_reg = 1'b1;
      repeat (7) tick;
      e = exp_q.pop_front();
      vectors++;
      if (o_irq !== 1'b1 || o_irq_id !== W'(e) || o_flags !== 8'h20) begin
         miscompares++;
         $display("FAIL ack_held: got irq=%b id=%0d flags=%h expected irq=1 id=%0d flags=20",
                  o_irq, o_irq_id, o_flags, e);
      end
      i_ack_reg = 1'b0;
      tick;
      do_ack;
      vectors++;
      if ({o_irq, o_flags} !== 9'h0) begin
         miscompares++;
         $display("FAIL ack_held_done: got %h expected 0", {o_irq, o_flags});
      end
   endtask

   task automatic test_ignored_ack;
      int e;
      bit ok;
      apply_reset;
      i_evt_pulse = 8'h80;
      tick;
      i_evt_pulse = '0;
      i_ack_reg = 1'b1;
      repeat (2) tick;
      i_ack_reg = 1'b0;
      tick;
      vectors++;
      if ({o_irq, o_flags, o_pending} !== {1'b0, 8'h80, 1'b0}) begin
         miscompares++;
         $display("FAIL ack_idle: got %h expected %h", {o_irq, o_flags, o_pending}, {1'b0, 8'h80, 1'b0});
      end
      i_evt_mask = 8'hFF;
      exp_q.push_back(7);
      wait_irq(3, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || o_irq_id !== W'(e)) begin
         miscompares++;
         $display("FAIL ack_idle_irq: got irq=%b id=%0d expected irq=1 id=%0d", ok, o_irq_id, e);
      end
      do_ack;
   endtask

   task automatic test_mask_and_reset;
      int e;
      bit ok;
      apply_reset;
      i_evt_pulse = 8'h01;
      tick;
      i_evt_pulse = '0;
      repeat (2) tick;
      vectors++;
      if ({o_irq, o_pending, o_flags} !== {1'b0, 1'b0, 8'h01}) begin
         miscompares++;
         $display("FAIL mask_off: got %h expected %h", {o_irq, o_pending, o_flags}, {1'b0, 1'b0, 8'h01});
      end
      i_evt_mask = 8'h01;
      exp_q.push_back(0);
      wait_irq(2, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || o_irq_id !== W'(e) || o_pending !== 1'b1) begin
         miscompares++;
         $display("FAIL mask_on: got irq=%b id=%0d pend=%b expected irq=1 id=%0d pend=1",
                  ok, o_irq_id, o_pending, e);
      end
      i_evt_mask = '0;
      repeat (2) tick;
      vectors++;
      if (o_irq !== 1'b1 || o_irq_id !== W'(0)) begin
         miscompares++;
         $display("FAIL mask_hold: got irq=%b id=%0d expected irq=1 id=0", o_irq, o_irq_id);
      end
      i_evt_pulse = 8'h01;
      tick;
      i_evt_pulse = '0;
      vectors++;
      if (o_ovf !== 8'h01) begin
         miscompares++;
         $display("FAIL mid_ovf: got %h expected 01", o_ovf);
      end
      #1;
      rstn = 1'b0;
      #1;
      vectors++;
      if ({o_irq, o_flags, o_ovf, o_pending, o_irq_id} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset: got %h expected 0", {o_irq, o_flags, o_ovf, o_pending, o_irq_id});
      end
      #1;
      rstn = 1'b1;
      i_evt_mask = 8'hFF;
      repeat (3) tick;
      vectors++;
      if ({o_irq, o_pending, o_flags} !== 10'h0) begin
         miscompares++;
         $display("FAIL post_reset: got %h expected 0", {o_irq, o_pending, o_flags});
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_round_robin;
      test_overrun;
      test_withdraw;
      test_ignored_ack;
      test_mask_and_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
